// File: rtl/pp_cmd_driver.sv
// rtl/pp_cmd_driver.sv - credit-based request/response driver for a fixed-latency pp core
// Optional macro PP_DRV_STATS_EN adds issued_cnt/completed_cnt outputs.
module pp_cmd_driver #(
   parameter int NUM_SIZE      = 32,
   parameter int CMD_SIZE_LOG2 = 3,
   parameter int LATENCY       = 2,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [(2**CMD_SIZE_LOG2)-1:0]   req_cmd,
   input  logic [NUM_SIZE-1:0]             req_in1,
   input  logic [NUM_SIZE-1:0]             req_in2,
   output logic [(2**CMD_SIZE_LOG2)-1:0]   cmd,
   output logic [NUM_SIZE-1:0]             in1,
   output logic [NUM_SIZE-1:0]             in2,
   input  logic                            out,
   input  logic [NUM_SIZE-1:0]             out1,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_out,
   output logic [NUM_SIZE-1:0]             rsp_out1
`ifdef PP_DRV_STATS_EN
   ,
   output logic [31:0]                     issued_cnt,
   output logic [31:0]                     completed_cnt
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic               issue;
   logic               pop;
   logic               capture;
   logic [LATENCY-1:0] vsr;
   logic [CW-1:0]      inflight;
   logic [CW-1:0]      inflight_next;
   logic [CW-1:0]      count;
   logic [CW-1:0]      count_next;
   logic [CW:0]        credit_next;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [NUM_SIZE:0]  mem [FIFO_DEPTH];

   assign issue     = req_valid & req_ready;
   assign pop       = rsp_valid & rsp_ready;
   assign capture   = vsr[LATENCY-1];
   assign rsp_valid = (count != '0);

   // Gate the head so the response outputs read zero whenever the FIFO is empty.
   assign {rsp_out, rsp_out1} = rsp_valid ? mem[rd_ptr] : '0;

   always_comb begin
      inflight_next = inflight;
      count_next    = count;
      if (issue) begin
         inflight_next = inflight_next + 1'b1;
      end
      if (capture) begin
         inflight_next = inflight_next - 1'b1;
         count_next    = count_next + 1'b1;
      end
      if (pop) begin
         count_next = count_next - 1'b1;
      end
      credit_next = {1'b0, inflight_next} + {1'b0, count_next};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd       <= '0;
         in1       <= '0;
         in2       <= '0;
         vsr       <= '0;
         inflight  <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         req_ready <= 1'b0;
      end else begin
         cmd <= issue ? req_cmd : '0;
         if (issue) begin
            in1 <= req_in1;
            in2 <= req_in2;
         end
         vsr[0] <= issue;
         for (int i = 1; i < LATENCY; i++) begin
            vsr[i] <= vsr[i-1];
         end
         inflight <= inflight_next;
         count    <= count_next;
         // Ready looks at next-cycle credit so it is a pure register output.
         req_ready <= (int'(credit_next) < FIFO_DEPTH);
         if (capture) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         mem[wr_ptr] <= {out, out1};
      end
   end

`ifdef PP_DRV_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issued_cnt    <= '0;
         completed_cnt <= '0;
      end else begin
         if (issue) begin
            issued_cnt <= issued_cnt + 32'd1;
         end
         if (pop) begin
            completed_cnt <= completed_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
